// File: rtl/axis_dm_pkg.sv
// axis_dm_pkg: shared constants for the DataMover command generator.
// Field offsets, status bits, FSM encoding and the 4 KB page size.
package axis_dm_pkg;

  // TAG sits at ADDR_WIDTH + TAG_REL
  localparam int TAG_REL  = 32;
  localparam int DRR_BIT  = 31;
  localparam int EOF_BIT  = 30;
  localparam int DSA_LO   = 24;
  localparam int TYPE_BIT = 23;

  localparam int STS_OKAY   = 7;
  localparam int STS_SLVERR = 6;
  localparam int STS_DECERR = 5;
  localparam int STS_INTERR = 4;

  localparam logic [31:0] PAGE_BYTES = 32'd4096;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_LOAD  = S_LOAD,
    ST_ISSUE = S_ISSUE,
    ST_DRAIN = S_DRAIN
  } state_t;

endpackage

// File: rtl/axis_dm_burst_calc.sv
// axis_dm_burst_calc: size of the next burst, clipped to the burst
// limit and to the end of the current 4 KB page.
module axis_dm_burst_calc
  import axis_dm_pkg::*;
#(
  parameter int MAX_BURST_BYTES = 512
) (
  input  logic [31:0] remaining,
  input  logic [11:0] addr_lo,
  output logic [31:0] bsz,
  output logic        last
);

  logic [31:0] page_left;
  logic [31:0] lim;

  always_comb begin
    page_left = PAGE_BYTES - {20'd0, addr_lo};
    lim = (page_left < 32'(MAX_BURST_BYTES))
        ? page_left : 32'(MAX_BURST_BYTES);
    bsz = (remaining < lim) ? remaining : lim;
    last = (bsz == remaining);
  end

endmodule

// File: rtl/axis_dm_cmd_gen.sv
// axis_dm_cmd_gen: splits a buffer region into DataMover commands,
// one-shot or as a ring, bounded by returned status beats.
module axis_dm_cmd_gen
  import axis_dm_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int BTT_WIDTH       = 23,
  parameter int MAX_BURST_BYTES = 512,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CMD_WIDTH       = ADDR_WIDTH + 40
) (
  input  logic                  clk,
  input  logic                  resetn,
  output logic [CMD_WIDTH-1:0]  m_axis_cmd_tdata,
  output logic                  m_axis_cmd_tvalid,
  input  logic                  m_axis_cmd_tready,
  output logic                  m_axis_cmd_tlast,
  input  logic [7:0]            s_axis_sts_tdata,
  input  logic                  s_axis_sts_tvalid,
  output logic                  s_axis_sts_tready,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  soft_reset,
  input  logic                  circular,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [31:0]           cap_size,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           wrap_cnt,
  output logic [3:0]            outstanding
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           rem;
  logic [31:0]           cap_q;
  logic                  circ_q;
  logic                  halt;
  logic [3:0]            tag;
  logic [31:0]           bsz;
  logic                  last;
  logic                  sts_fire;
  logic                  sts_err;
  logic                  cmd_fire;
  logic                  halt_now;
  logic                  can_issue;
  logic [3:0]            out_nxt;
  logic [CMD_WIDTH-1:0]  cmd_nxt;
  logic                  unused_bits;

  axis_dm_burst_calc #(
    .MAX_BURST_BYTES (MAX_BURST_BYTES)
  ) u_calc (
    .remaining (rem),
    .addr_lo   (addr[11:0]),
    .bsz       (bsz),
    .last      (last)
  );

  assign m_axis_cmd_tlast  = 1'b1;
  assign s_axis_sts_tready = 1'b1;
  assign busy = (state != ST_IDLE);

  assign unused_bits = ^{s_axis_sts_tdata[STS_OKAY],
                         s_axis_sts_tdata[3:0],
                         bsz[31:BTT_WIDTH]};

  // a status with nothing outstanding is stale and dropped entirely
  always_comb begin
    sts_fire = s_axis_sts_tvalid && (outstanding != 4'd0);
    sts_err = sts_fire && (s_axis_sts_tdata[STS_SLVERR]
            || s_axis_sts_tdata[STS_DECERR]
            || s_axis_sts_tdata[STS_INTERR]);
    cmd_fire = m_axis_cmd_tvalid && m_axis_cmd_tready;
    out_nxt = outstanding + {3'd0, cmd_fire}
            - {3'd0, sts_fire};
    halt_now = halt || stop || sts_err;
    can_issue = out_nxt < 4'(MAX_OUTSTANDING);
  end

  always_comb begin
    cmd_nxt = '0;
    cmd_nxt[ADDR_WIDTH+TAG_REL +: 4] = tag;
    cmd_nxt[32 +: ADDR_WIDTH] = addr;
    cmd_nxt[DRR_BIT] = 1'b0;
    cmd_nxt[EOF_BIT] = 1'b1;
    cmd_nxt[DSA_LO +: 6] = 6'd0;
    cmd_nxt[TYPE_BIT] = 1'b1;
    cmd_nxt[BTT_WIDTH-1:0] = bsz[BTT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state             <= ST_IDLE;
      addr              <= '0;
      base_q            <= '0;
      rem               <= '0;
      cap_q             <= '0;
      circ_q            <= 1'b0;
      halt              <= 1'b0;
      tag               <= '0;
      m_axis_cmd_tdata  <= '0;
      m_axis_cmd_tvalid <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      wrap_cnt          <= '0;
      outstanding       <= '0;
    end else begin
      done <= 1'b0;
      if (soft_reset) begin
        state             <= ST_IDLE;
        m_axis_cmd_tvalid <= 1'b0;
        outstanding       <= '0;
        err               <= 1'b0;
        wrap_cnt          <= '0;
        tag               <= '0;
        halt              <= 1'b0;
      end else begin
        outstanding <= out_nxt;
        if (sts_err) err <= 1'b1;
        if (state != ST_IDLE && (stop || sts_err))
          halt <= 1'b1;
        unique case (state)
          ST_IDLE: begin
            halt <= 1'b0;
            if (start) begin
              if (cap_size != 32'd0) begin
                addr   <= base_addr;
                base_q <= base_addr;
                rem    <= cap_size;
                cap_q  <= cap_size;
                circ_q <= circular;
                state  <= ST_LOAD;
              end else begin
                done <= 1'b1;
              end
            end
          end
          ST_LOAD: begin
            m_axis_cmd_tdata <= cmd_nxt;
            if (halt_now) begin
              state <= ST_DRAIN;
            end else begin
              state             <= ST_ISSUE;
              m_axis_cmd_tvalid <= can_issue;
            end
          end
          ST_ISSUE: begin
            if (m_axis_cmd_tvalid) begin
              if (m_axis_cmd_tready) begin
                m_axis_cmd_tvalid <= 1'b0;
                tag  <= tag + 4'd1;
                addr <= addr + ADDR_WIDTH'(bsz);
                rem  <= rem - bsz;
                if (last && circ_q) begin
                  addr     <= base_q;
                  rem      <= cap_q;
                  wrap_cnt <= wrap_cnt + 16'd1;
                end
                if (halt_now || (last && !circ_q))
                  state <= ST_DRAIN;
                else
                  state <= ST_LOAD;
              end
            end else if (halt_now) begin
              state <= ST_DRAIN;
            end else if (can_issue) begin
              m_axis_cmd_tvalid <= 1'b1;
            end
          end
          ST_DRAIN: begin
            if (outstanding == 4'd0) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_dm_cmd_gen.sv
// tb_axis_dm_cmd_gen: randomized bench with a transaction-level
// model of the command stream, outstanding count and error flag.
module tb_axis_dm_cmd_gen;

  localparam int AW = 32;
  localparam int BW = 23;
  localparam int MB = 512;
  localparam int MO = 2;
  localparam int CW = AW + 40;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [CW-1:0] cmd_tdata;
  logic          cmd_tvalid;
  logic          cmd_tready = 1'b0;
  logic          cmd_tlast;
  logic [7:0]    sts_tdata = '0;
  logic          sts_tvalid = 1'b0;
  logic          sts_tready;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          soft_reset = 1'b0;
  logic          circular = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [31:0]   cap_size = '0;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   wrap_cnt;
  logic [3:0]    outstanding;

  always #5 clk = ~clk;

  axis_dm_cmd_gen #(
    .ADDR_WIDTH      (AW),
    .BTT_WIDTH       (BW),
    .MAX_BURST_BYTES (MB),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .m_axis_cmd_tdata  (cmd_tdata),
    .m_axis_cmd_tvalid (cmd_tvalid),
    .m_axis_cmd_tready (cmd_tready),
    .m_axis_cmd_tlast  (cmd_tlast),
    .s_axis_sts_tdata  (sts_tdata),
    .s_axis_sts_tvalid (sts_tvalid),
    .s_axis_sts_tready (sts_tready),
    .start             (start),
    .stop              (stop),
    .soft_reset        (soft_reset),
    .circular          (circular),
    .base_addr         (base_addr),
    .cap_size          (cap_size),
    .busy              (busy),
    .done              (done),
    .err               (err),
    .wrap_cnt          (wrap_cnt),
    .outstanding       (outstanding)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [127:0] act,
                     logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // reference state
  logic [31:0] m_addr = '0, m_rem = '0;
  logic [31:0] m_base = '0, m_cap = '0;
  bit          m_circ = 0;
  logic [3:0]  m_tag = '0;
  int          m_out = 0;
  bit          m_err = 0;
  logic [15:0] m_wrap = '0;
  bit          m_halt = 0;
  int          hs_cnt = 0, hs_after_halt = 0, done_cnt = 0;
  longint      cyc = 0;
  longint      hs_cyc[$];
  logic [31:0] hs_addr[$];
  logic [31:0] hs_btt[$];
  int          sts_mode = 0;
  bit          inj_err = 0, inj_ok = 0, rnd_ready = 0;
  bit          mon_en = 0;

  function automatic logic [31:0] burst(logic [31:0] a,
                                        logic [31:0] r);
    logic [31:0] page, b;
    page = 32'd4096 - (a % 32'd4096);
    b = r;
    if (b > MB) b = MB;
    if (b > page) b = page;
    return b;
  endfunction

  initial forever begin
    logic [31:0] b;
    logic [CW-1:0] exp;
    bit sts_ok, sts_bad, pre_halt;
    @(posedge clk);
    cyc++;
    if (resetn) begin
      if (done) done_cnt++;
      if (soft_reset) begin
        m_out = 0; m_err = 0; m_wrap = '0; m_tag = '0;
      end else begin
        sts_ok = sts_tvalid && m_out > 0;
        sts_bad = sts_ok && (|sts_tdata[6:4]);
        pre_halt = m_halt;
        if (cmd_tvalid && cmd_tready) begin
          b = burst(m_addr, m_rem);
          exp = {4'd0, m_tag, m_addr, 8'h40, 1'b1, b[BW-1:0]};
          chk("cmd_word", cmd_tdata, exp);
          hs_cyc.push_back(cyc);
          hs_addr.push_back(cmd_tdata[63:32]);
          hs_btt.push_back({9'd0, cmd_tdata[BW-1:0]});
          hs_cnt++;
          if (pre_halt) hs_after_halt++;
          m_tag++;
          m_addr += b;
          m_rem -= b;
          if (m_rem == 0 && m_circ) begin
            m_addr = m_base; m_rem = m_cap; m_wrap++;
          end
          m_out++;
        end
        if (sts_ok) m_out--;
        if (sts_bad) m_err = 1;
        if (stop || sts_bad) m_halt = 1;
      end
    end
  end

  // per-cycle compare against the model
  initial begin
    bit pv, pr, ps;
    logic [CW-1:0] pd;
    pv = 0; pr = 0; ps = 0; pd = '0;
    forever begin
      @(negedge clk);
      if (resetn && mon_en) begin
        chk("outstanding", outstanding, 4'(m_out));
        chk("err", err, m_err);
        chk("wrap_cnt", wrap_cnt, m_wrap);
        chk("tlast", cmd_tlast, 1'b1);
        chk("sts_tready", sts_tready, 1'b1);
        if (pv && !pr && !ps) begin
          chk("hold_valid", cmd_tvalid, 1'b1);
          chk("hold_data", cmd_tdata, pd);
        end
        if (cmd_tvalid)
          chk("out_limit", outstanding < MO, 1'b1);
        pv = cmd_tvalid; pr = cmd_tready;
        ps = soft_reset; pd = cmd_tdata;
      end else begin
        pv = 0;
      end
    end
  end

  // status return and random ready
  initial forever begin
    @(posedge clk);
    #1;
    sts_tvalid = 1'b0;
    sts_tdata = 8'h00;
    if (inj_err && m_out > 0) begin
      sts_tvalid = 1'b1; sts_tdata = 8'hC1; inj_err = 0;
    end else if (inj_ok && m_out > 0) begin
      sts_tvalid = 1'b1; sts_tdata = 8'h80; inj_ok = 0;
    end else if (sts_mode == 1 && m_out > 0) begin
      sts_tvalid = 1'b1; sts_tdata = 8'h80;
    end else if (sts_mode == 2 && m_out > 0
                 && $urandom_range(0, 2) == 0) begin
      sts_tvalid = 1'b1; sts_tdata = 8'h80;
    end
    if (rnd_ready) cmd_tready = 1'($urandom_range(0, 1));
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic arm(logic [31:0] b, logic [31:0] c, bit ci);
    m_addr = b; m_rem = c; m_base = b; m_cap = c;
    m_circ = ci; m_halt = 0; hs_after_halt = 0;
    base_addr = b; cap_size = c; circular = ci;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_hs(int n, int budget, string nm);
    int k = 0;
    while (hs_cnt < n && k < budget) begin tick(1); k++; end
    chk(nm, hs_cnt >= n, 1'b1);
  endtask

  task automatic wait_done(int d0, int budget, string nm);
    int k = 0;
    while (done_cnt <= d0 && k < budget) begin tick(1); k++; end
    chk(nm, done_cnt > d0, 1'b1);
    tick(4);
    chk({nm, "_once"}, done_cnt - d0, 1);
    chk({nm, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int h0, d0;
    bit saw;
    tick(3);
    chk("rst_tvalid", cmd_tvalid, 1'b0);
    chk("rst_tdata", cmd_tdata, '0);
    chk("rst_tlast", cmd_tlast, 1'b1);
    chk("rst_ststready", sts_tready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out", outstanding, 4'd0);
    resetn = 1'b1;
    mon_en = 1;
    tick(2);

    // aligned one-shot
    sts_mode = 1; cmd_tready = 1'b1;
    h0 = hs_cnt; d0 = done_cnt;
    arm(32'h1000_0000, 2048, 0);
    chk("t1_lat_early", cmd_tvalid, 1'b0);
    tick(1);
    chk("t1_latency", cmd_tvalid, 1'b1);
    wait_done(d0, 200, "t1_done");
    chk("t1_count", hs_cnt - h0, 4);
    chk("t1_addr0", hs_addr[h0], 32'h1000_0000);
    chk("t1_addr3", hs_addr[h0+3], 32'h1000_0600);
    chk("t1_btt3", hs_btt[h0+3], 32'd512);
    chk("t1_cadence", hs_cyc[h0+1] - hs_cyc[h0], 2);

    // 4 KB crossing
    h0 = hs_cnt; d0 = done_cnt;
    arm(32'h0000_0F00, 1024, 0);
    wait_done(d0, 200, "t2_done");
    chk("t2_count", hs_cnt - h0, 3);
    chk("t2_btt0", hs_btt[h0], 32'd256);
    chk("t2_addr1", hs_addr[h0+1], 32'h1000);
    chk("t2_btt1", hs_btt[h0+1], 32'd512);
    chk("t2_addr2", hs_addr[h0+2], 32'h1200);
    chk("t2_btt2", hs_btt[h0+2], 32'd256);

    // circular
    h0 = hs_cnt; d0 = done_cnt;
    arm(32'h0, 1024, 1);
    wait_hs(h0 + 4, 200, "t3_hs4");
    chk("t3_wrap2", wrap_cnt, 16'd2);
    wait_hs(h0 + 5, 200, "t3_hs5");
    chk("t3_addr5", hs_addr[h0+4], 32'h0);
    stop = 1'b1; tick(1); stop = 1'b0;
    wait_done(d0, 200, "t3_done");

    // backpressure by outstanding limit
    sts_mode = 0; cmd_tready = 1'b1;
    h0 = hs_cnt; d0 = done_cnt;
    arm(32'h2000, 4096, 0);
    tick(20);
    chk("t4_stall_cnt", hs_cnt - h0, 2);
    chk("t4_stall_v", cmd_tvalid, 1'b0);
    chk("t4_out2", outstanding, 4'd2);
    cmd_tready = 1'b0;
    inj_ok = 1;
    tick(3);
    chk("t4_resume", cmd_tvalid, 1'b1);
    tick(6);
    chk("t4_held_cnt", hs_cnt - h0, 2);
    cmd_tready = 1'b1;
    wait_hs(h0 + 3, 20, "t4_hs3");
    sts_mode = 2; rnd_ready = 1;
    wait_done(d0, 1000, "t4_done");
    chk("t4_count", hs_cnt - h0, 8);
    rnd_ready = 0; cmd_tready = 1'b1;

    // error status
    h0 = hs_cnt; d0 = done_cnt;
    rnd_ready = 1;
    arm(32'h3000_0000, 20000, 0);
    wait_hs(h0 + 4, 500, "t5_hs4");
    inj_err = 1;
    begin
      int k = 0;
      while (!err && k < 100) begin tick(1); k++; end
    end
    chk("t5_err", err, 1'b1);
    wait_done(d0, 1000, "t5_done");
    chk("t5_no_more", hs_after_halt <= 1, 1'b1);
    chk("t5_err_sticky", err, 1'b1);
    soft_reset = 1'b1; tick(1); soft_reset = 1'b0;
    chk("t5_err_clr", err, 1'b0);
    rnd_ready = 0;

    // stop with a stalled command
    sts_mode = 1; cmd_tready = 1'b0;
    h0 = hs_cnt; d0 = done_cnt;
    arm(32'h4000, 4096, 0);
    tick(1);
    chk("t6_valid", cmd_tvalid, 1'b1);
    stop = 1'b1; tick(1); stop = 1'b0;
    tick(3);
    chk("t6_still", cmd_tvalid, 1'b1);
    chk("t6_none", hs_cnt - h0, 0);
    cmd_tready = 1'b1;
    wait_done(d0, 200, "t6_done");
    chk("t6_one", hs_cnt - h0, 1);

    // zero size
    d0 = done_cnt;
    arm(32'h5000, 0, 0);
    chk("t7_done", done, 1'b1);
    saw = 0;
    repeat (10) begin tick(1); saw |= cmd_tvalid; end
    chk("t7_novalid", saw, 1'b0);
    chk("t7_once", done_cnt - d0, 1);

    // randomized one-shot runs
    sts_mode = 2; rnd_ready = 1;
    for (int r = 0; r < 6; r++) begin
      d0 = done_cnt;
      arm($urandom, 32'($urandom_range(1, 6000)), 0);
      if (r == 0) begin
        tick(3);
        base_addr = 32'hDEAD_0000; cap_size = 32'd64;
        start = 1'b1; tick(1); start = 1'b0;
      end
      wait_done(d0, 3000, "rnd_done");
      chk("rnd_consumed", m_rem, 32'd0);
    end

    // reset in the middle of a transfer
    h0 = hs_cnt;
    arm(32'h6000, 8192, 0);
    wait_hs(h0 + 2, 500, "t9_hs2");
    #2 resetn = 1'b0;
    #1;
    chk("t9_tvalid", cmd_tvalid, 1'b0);
    chk("t9_out", outstanding, 4'd0);
    chk("t9_busy", busy, 1'b0);
    chk("t9_tdata", cmd_tdata, '0);
    m_out = 0; m_err = 0; m_wrap = '0; m_tag = '0;
    rnd_ready = 0; cmd_tready = 1'b1;
    tick(2);
    resetn = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
